// File: rtl/ysyx_25040109_csr_pkg.sv
// ysyx_25040109_csr_pkg: CSR addresses, op and state encodings, mstatus fields and trap helpers.
package ysyx_25040109_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] DEFAULT_ECALL_CAUSE = 32'd11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [2:0] {
        OP_CSRRW = 3'd0,
        OP_CSRRS = 3'd1,
        OP_CSRRC = 3'd2,
        OP_ECALL = 3'd3,
        OP_MRET  = 3'd4
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE, S_EXEC, S_T_EPC, S_T_CAUSE, S_T_STAT, S_T_VEC, S_R_STAT, S_R_EPC, S_RESP
    } state_e;

    function automatic logic csr_legal(input logic [11:0] a);
        return a == CSR_MSTATUS || a == CSR_MTVEC || a == CSR_MEPC || a == CSR_MCAUSE;
    endfunction

    function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE] = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MIE] = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/ysyx_25040109_csr_alu.sv
// ysyx_25040109_csr_alu: next CSR value for CSRRW / CSRRS / CSRRC.
module ysyx_25040109_csr_alu
    import ysyx_25040109_csr_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] old_i,
    input  logic [31:0] src_i,
    output logic [31:0] new_o
);

    always_comb new_o = op_i == OP_CSRRS ? old_i | src_i :
                        op_i == OP_CSRRC ? old_i & ~src_i : src_i;

endmodule

// File: rtl/ysyx_25040109_csr_ctrl.sv
// ysyx_25040109_csr_ctrl: sequences CSR read-modify-writes, ECALL entry and MRET over one CSR port.
// Define CSR_CTRL_MSTATUS_EN to add the mstatus MIE/MPIE/MPP updates on trap entry and return.
module ysyx_25040109_csr_ctrl
    import ysyx_25040109_csr_pkg::*;
#(
    parameter logic [31:0] ECALL_CAUSE = DEFAULT_ECALL_CAUSE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_src,
    input  logic        req_src_x0,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_illegal,
    output logic        resp_redirect,
    output logic [31:0] resp_pc,
    output logic        csr_we,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata
);

`ifdef CSR_CTRL_MSTATUS_EN
    localparam state_e AFTER_CAUSE = S_T_STAT;
    localparam state_e MRET_FIRST  = S_R_STAT;
`else
    localparam state_e AFTER_CAUSE = S_T_VEC;
    localparam state_e MRET_FIRST  = S_R_EPC;
`endif

    state_e      state_q;
    logic [2:0]  op_q;
    logic [11:0] addr_q;
    logic [31:0] src_q, pc_q, rdata_q, resp_pc_q, alu_new;
    logic        src_x0_q, illegal_q, redirect_q, legal;

    ysyx_25040109_csr_alu u_alu (
        .op_i  (op_q),
        .old_i (csr_rdata),
        .src_i (src_q),
        .new_o (alu_new)
    );

    assign legal         = csr_legal(addr_q);
    assign req_ready     = state_q == S_IDLE;
    assign resp_valid    = state_q == S_RESP;
    assign resp_rdata    = rdata_q;
    assign resp_illegal  = illegal_q;
    assign resp_redirect = redirect_q;
    assign resp_pc       = resp_pc_q;

    // Address is kept apart from the write path since csr_rdata is a combinational function of it.
    always_comb csr_addr = rst ? 12'h0 :
                           state_q == S_EXEC ? addr_q :
                           state_q == S_T_EPC || state_q == S_R_EPC ? CSR_MEPC :
                           state_q == S_T_CAUSE ? CSR_MCAUSE :
                           state_q == S_T_STAT || state_q == S_R_STAT ? CSR_MSTATUS :
                           state_q == S_T_VEC ? CSR_MTVEC : 12'h0;

    always_comb begin
        csr_we = 1'b0;
        csr_wdata = 32'h0;
        if (!rst) begin
            case (state_q)
                S_EXEC: begin
                    csr_wdata = alu_new;
                    csr_we = legal && (op_q == OP_CSRRW || !src_x0_q);
                end
                S_T_EPC: begin
                    csr_wdata = pc_q;
                    csr_we = 1'b1;
                end
                S_T_CAUSE: begin
                    csr_wdata = ECALL_CAUSE;
                    csr_we = 1'b1;
                end
                S_T_STAT: begin
                    csr_wdata = trap_mstatus(csr_rdata);
                    csr_we = 1'b1;
                end
                S_R_STAT: begin
                    csr_wdata = mret_mstatus(csr_rdata);
                    csr_we = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q <= 3'h0;
            addr_q <= 12'h0;
            src_q <= 32'h0;
            src_x0_q <= 1'b0;
            pc_q <= 32'h0;
            rdata_q <= 32'h0;
            resp_pc_q <= 32'h0;
            illegal_q <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (req_valid) begin
                    op_q <= req_op;
                    addr_q <= req_addr;
                    src_q <= req_src;
                    src_x0_q <= req_src_x0;
                    pc_q <= req_pc;
                    rdata_q <= 32'h0;
                    resp_pc_q <= 32'h0;
                    redirect_q <= 1'b0;
                    illegal_q <= req_op > OP_MRET;
                    state_q <= req_op == OP_ECALL ? S_T_EPC :
                               req_op == OP_MRET ? MRET_FIRST :
                               req_op > OP_MRET ? S_RESP : S_EXEC;
                end
                S_EXEC: begin
                    rdata_q <= legal ? csr_rdata : 32'h0;
                    illegal_q <= !legal;
                    state_q <= S_RESP;
                end
                S_T_EPC:   state_q <= S_T_CAUSE;
                S_T_CAUSE: state_q <= AFTER_CAUSE;
                S_T_STAT:  state_q <= S_T_VEC;
                S_T_VEC: begin
                    resp_pc_q <= {csr_rdata[31:2], 2'b00};
                    redirect_q <= 1'b1;
                    state_q <= S_RESP;
                end
                S_R_STAT:  state_q <= S_R_EPC;
                S_R_EPC: begin
                    resp_pc_q <= csr_rdata;
                    redirect_q <= 1'b1;
                    state_q <= S_RESP;
                end
                S_RESP:    if (resp_ready) state_q <= S_IDLE;
                default:   state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25040109_csr_ctrl.sv
// tb_ysyx_25040109_csr_ctrl: directed bench with a CSR-file model and transaction-level expectations.
module tb_ysyx_25040109_csr_ctrl;

`ifdef CSR_CTRL_MSTATUS_EN
    localparam int MS = 1;
`else
    localparam int MS = 0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_src_x0 = 1'b0;
    logic [2:0]  req_op = 3'h0;
    logic [11:0] req_addr = 12'h0;
    logic [31:0] req_src = 32'h0, req_pc = 32'h0;
    logic        resp_valid, resp_ready = 1'b0, resp_illegal, resp_redirect;
    logic [31:0] resp_rdata, resp_pc;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata;

    always #5 clk = ~clk;

    ysyx_25040109_csr_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .req_src(req_src), .req_src_x0(req_src_x0), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_illegal(resp_illegal), .resp_redirect(resp_redirect), .resp_pc(resp_pc),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata)
    );

    // Bench-side CSR file; unknown addresses read as a marker so leaked reads are visible.
    logic [31:0] r_mstatus, r_mtvec, r_mepc, r_mcause;
    assign csr_rdata = csr_addr == 12'h300 ? r_mstatus : csr_addr == 12'h305 ? r_mtvec :
                       csr_addr == 12'h341 ? r_mepc : csr_addr == 12'h342 ? r_mcause : 32'hDEADBEEF;

    always @(posedge clk)
        if (csr_we)
            case (csr_addr)
                12'h300: r_mstatus <= csr_wdata;
                12'h305: r_mtvec <= csr_wdata;
                12'h341: r_mepc <= csr_wdata;
                12'h342: r_mcause <= csr_wdata;
                default: ;
            endcase

    int we_total = 0;
    always @(posedge clk) if (csr_we) we_total++;

    int checks = 0, passed = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model state and per-transaction expectations
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
    logic [31:0] e_rdata, e_pc, s_rdata, s_pc;
    logic        e_illegal, e_redirect, s_illegal, s_redirect, exp_active = 1'b0;
    int          e_lat, e_we;

    function automatic logic [31:0] mread(input logic [11:0] a);
        return a == 12'h300 ? m_mstatus : a == 12'h305 ? m_mtvec : a == 12'h341 ? m_mepc : m_mcause;
    endfunction

    task automatic mwrite(input logic [11:0] a, input logic [31:0] v);
        case (a)
            12'h300: m_mstatus = v;
            12'h305: m_mtvec = v;
            12'h341: m_mepc = v;
            default: m_mcause = v;
        endcase
    endtask

    task automatic model(input logic [2:0] op, input logic [11:0] a, input logic [31:0] src, input logic x0,
                         input logic [31:0] pc);
        logic [31:0] old;
        logic        legal;
        legal = a == 12'h300 || a == 12'h305 || a == 12'h341 || a == 12'h342;
        e_rdata = 0; e_pc = 0; e_illegal = 0; e_redirect = 0; e_we = 0;
        if (op <= 3'd2) begin
            e_lat = 2;
            if (!legal) e_illegal = 1;
            else begin
                old = mread(a);
                e_rdata = old;
                if (op == 3'd0 || !x0) begin
                    e_we = 1;
                    mwrite(a, op == 3'd0 ? src : op == 3'd1 ? (old | src) : (old & ~src));
                end
            end
        end else if (op == 3'd3) begin
            e_lat = 4 + MS; e_we = 2 + MS;
            m_mepc = pc; m_mcause = 32'd11;
            if (MS == 1) m_mstatus = (m_mstatus & ~32'h1888) | 32'h1800 | (32'(m_mstatus[3]) << 7);
            e_redirect = 1; e_pc = m_mtvec & ~32'h3;
        end else if (op == 3'd4) begin
            e_lat = 2 + MS; e_we = MS;
            if (MS == 1) m_mstatus = (m_mstatus & ~32'h1888) | 32'h1880 | (32'(m_mstatus[7]) << 3);
            e_redirect = 1; e_pc = m_mepc;
        end else begin
            e_lat = 1; e_illegal = 1;
        end
    endtask

    // Per-cycle compare against the model while a response is expected.
    always @(negedge clk)
        if (!rst) begin
            chk("ready_valid_excl", 32'(req_ready & resp_valid), 32'h0);
            if (csr_we) chk("we_in_idle_or_resp", 32'(req_ready | resp_valid), 32'h0);
            if (exp_active && resp_valid) begin
                chk("resp_rdata", resp_rdata, e_rdata);
                chk("resp_illegal", 32'(resp_illegal), 32'(e_illegal));
                chk("resp_redirect", 32'(resp_redirect), 32'(e_redirect));
                chk("resp_pc", resp_pc, e_pc);
            end
        end

    task automatic check_regs();
        chk("mstatus", r_mstatus, m_mstatus);
        chk("mtvec", r_mtvec, m_mtvec);
        chk("mepc", r_mepc, m_mepc);
        chk("mcause", r_mcause, m_mcause);
    endtask

    task automatic do_req(input logic [2:0] op, input logic [11:0] a, input logic [31:0] src, input logic x0,
                          input logic [31:0] pc, input int stall);
        int n, lat, base;
        model(op, a, src, x0, pc);
        req_op = op; req_addr = a; req_src = src; req_src_x0 = x0; req_pc = pc; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("req_ready_idle", 32'(req_ready), 32'h1);
        exp_active = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        base = we_total;
        lat = 1;
        while (!resp_valid && lat < 12) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", 32'(lat), 32'(e_lat));
        s_rdata = resp_rdata; s_pc = resp_pc; s_illegal = resp_illegal; s_redirect = resp_redirect;
        repeat (stall) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(resp_valid), 32'h1);
            chk("stall_req_ready", 32'(req_ready), 32'h0);
            chk("stall_rdata", resp_rdata, s_rdata);
            chk("stall_pc", resp_pc, s_pc);
            chk("stall_flags", {30'h0, resp_illegal, resp_redirect}, {30'h0, s_illegal, s_redirect});
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        exp_active = 1'b0;
        chk("back_idle", 32'(req_ready), 32'h1);
        chk("resp_dropped", 32'(resp_valid), 32'h0);
        chk("write_count", 32'(we_total - base), 32'(e_we));
        check_regs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        r_mstatus <= 32'h1800; r_mtvec <= 32'h80000103; r_mepc <= 32'h0; r_mcause <= 32'h5;
        m_mstatus = 32'h1800; m_mtvec = 32'h80000103; m_mepc = 32'h0; m_mcause = 32'h5;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_flags", {30'h0, resp_illegal, resp_redirect}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_pc", resp_pc, 32'h0);
        chk("rst_csr_we", 32'(csr_we), 32'h0);
        chk("rst_csr_addr", 32'(csr_addr), 32'h0);

        do_req(3'd1, 12'h300, 32'h8, 1'b0, 32'h0, 0);
        chk("lit_rs_rdata", s_rdata, 32'h1800);
        chk("lit_rs_mstatus", r_mstatus, 32'h1808);

        do_req(3'd2, 12'h342, 32'hFFFFFFFF, 1'b1, 32'h0, 0);
        chk("lit_rc_x0_rdata", s_rdata, 32'h5);
        chk("lit_rc_x0_mcause", r_mcause, 32'h5);

        do_req(3'd3, 12'h7C0, 32'h0, 1'b0, 32'h80000010, 1);
        chk("lit_ecall_mepc", r_mepc, 32'h80000010);
        chk("lit_ecall_mcause", r_mcause, 32'd11);
        chk("lit_ecall_pc", s_pc, 32'h80000100);
        chk("lit_ecall_redirect", 32'(s_redirect), 32'h1);
        chk("lit_ecall_mstatus", r_mstatus, MS == 1 ? 32'h1880 : 32'h1808);

        do_req(3'd0, 12'h341, 32'h80000014, 1'b0, 32'h0, 0);
        chk("lit_rw_old_mepc", s_rdata, 32'h80000010);
        do_req(3'd4, 12'h000, 32'h0, 1'b0, 32'h0, 0);
        chk("lit_mret_pc", s_pc, 32'h80000014);
        chk("lit_mret_mstatus", r_mstatus, MS == 1 ? 32'h1888 : 32'h1808);

        do_req(3'd0, 12'h7C0, 32'h12345678, 1'b0, 32'h0, 5);
        chk("lit_illegal_flag", 32'(s_illegal), 32'h1);
        chk("lit_illegal_rdata", s_rdata, 32'h0);

        do_req(3'd6, 12'h300, 32'hFFFFFFFF, 1'b0, 32'h0, 2);
        chk("lit_reserved_flag", 32'(s_illegal), 32'h1);

        do_req(3'd2, 12'h300, 32'h8, 1'b0, 32'h0, 0);
        do_req(3'd0, 12'h305, 32'h12345679, 1'b0, 32'h0, 0);
        do_req(3'd3, 12'h000, 32'h0, 1'b0, 32'h00000100, 0);
        chk("lit_ecall_align", s_pc, 32'h12345678);
        do_req(3'd0, 12'h342, 32'h7, 1'b0, 32'h0, 0);

        // Abandon an ECALL while it sits in T_CAUSE: mepc is already written, mcause must not be.
        req_op = 3'd3; req_pc = 32'h00000200; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_req_ready", 32'(req_ready), 32'h1);
        chk("midrst_csr_we", 32'(csr_we), 32'h0);
        chk("midrst_resp_valid", 32'(resp_valid), 32'h0);
        chk("midrst_csr_addr", 32'(csr_addr), 32'h0);
        chk("midrst_mepc", r_mepc, 32'h00000200);
        chk("midrst_mcause", r_mcause, 32'h7);
        rst = 1'b0;
        m_mepc = 32'h00000200;
        check_regs();

        do_req(3'd1, 12'h342, 32'h0, 1'b1, 32'h0, 0);
        chk("lit_after_rst_rdata", s_rdata, 32'h7);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
